// File: rtl/sram_param_wrapper.sv
// sram_param_wrapper
//   Behavioural single-port SRAM with configurable width, depth and access
//   latency. Supports per-byte write enables and address range checking.
//   An access completes only after its inputs have been held stable for
//   LATENCY cycles. Progress is reported on sram_state.
//
//   Optional feature macro: SRAM_STRICT_EN
//     defined   : any input change during a BUSY phase raises ERROR.
//     undefined : an input change during BUSY restarts the access.
//
// Ports
//   clk          in   1          clock, rising edge
//   n_rst        in   1          asynchronous reset, active low
//   address      in   ADDR_W     word address
//   read_enable  in   1          read request level
//   write_enable in   1          write request level
//   write_data   in   DATA_W     write data
//   byte_en      in   DATA_W/8   byte write mask
//   read_data    out  DATA_W     mem[address] in read ACCESS, else BAD_PATTERN
//   sram_state   out  2          0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
module sram_param_wrapper #(
    parameter int          ADDR_W      = 10,
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter int          LATENCY     = 3,
    parameter logic [31:0] BAD_PATTERN = 32'hBAD1BAD1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read_enable,
    input  logic                write_enable,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   read_data,
    output logic [1:0]          sram_state
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    // BAD_PATTERN replicated (or truncated) to the data width
    function automatic logic [DATA_W-1:0] rep_bad();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W; i++) v[i] = BAD_PATTERN[i % 32];
        return v;
    endfunction
    localparam logic [DATA_W-1:0] BAD_WORD = rep_bad();

    typedef enum logic [2:0] {IDLE, RBUSY, WBUSY, RACC, WACC, ERR} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [ADDR_W-1:0]  prev_addr;
    logic [DATA_W-1:0]  prev_wdata;
    logic [NB-1:0]      prev_ben;
    logic               prev_ren, prev_wen;
    logic               ac, dc, ec, oor, busy, commit;

    logic [DATA_W-1:0]  mem [DEPTH];

    assign ac   = address != prev_addr;
    assign dc   = (write_data != prev_wdata) || (byte_en != prev_ben);
    assign ec   = (read_enable != prev_ren) || (write_enable != prev_wen);
    assign oor  = {1'b0, address} >= (ADDR_W+1)'(DEPTH);
    assign busy = (state == RBUSY) || (state == WBUSY);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            prev_addr  <= '0;
            prev_wdata <= '0;
            prev_ben   <= '0;
            prev_ren   <= 1'b0;
            prev_wen   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            prev_addr  <= address;
            prev_wdata <= write_data;
            prev_ben   <= byte_en;
            prev_ren   <= read_enable;
            prev_wen   <= write_enable;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (read_enable && write_enable) begin
            state_nx = ERR;
        end else if (!read_enable && !write_enable) begin
            state_nx = IDLE;
        end else if (oor) begin
            state_nx = ERR;
        end else if (state == ERR) begin
            state_nx = ERR;
`ifdef SRAM_STRICT_EN
        end else if (busy && (ac || dc || ec)) begin
            state_nx = ERR;
`endif
        // IDLE with a stable enable is not normally reachable; treating it
        // as a fresh request keeps the FSM from parking there.
        end else if (read_enable && (ac || ec || state == IDLE)) begin
            state_nx = RBUSY;
            cnt_nx   = '0;
        end else if (write_enable && (ac || dc || ec || state == IDLE)) begin
            state_nx = WBUSY;
            cnt_nx   = '0;
        end else if (busy) begin
            if (cnt == CNT_LAST) state_nx = (state == RBUSY) ? RACC : WACC;
            else                 cnt_nx   = cnt + 1'b1;
        end
    end

    // Single commit point: the WBUSY->WACC edge. Reset forces IDLE, so an
    // access interrupted by reset never reaches here.
    assign commit = (state == WBUSY) && (state_nx == WACC);

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < NB; i++)
                if (byte_en[i]) mem[address][8*i +: 8] <= write_data[8*i +: 8];
        end
    end

    assign read_data = (state == RACC) ? mem[prev_addr] : BAD_WORD;

    always_comb begin
        case (state)
            IDLE:         sram_state = 2'd0;
            RBUSY, WBUSY: sram_state = 2'd1;
            RACC, WACC:   sram_state = 2'd2;
            default:      sram_state = 2'd3;
        endcase
    end

endmodule

// File: tb/tb_sram_param_wrapper.sv
module tb_sram_param_wrapper;

    localparam logic [31:0] BAD = 32'hBAD1BAD1;

    logic        clk;
    logic        n_rst;
    logic [9:0]  address;
    logic        read_enable, write_enable;
    logic [31:0] write_data;
    logic [3:0]  byte_en;
    logic [31:0] read_data, read_data2;
    logic [1:0]  sram_state, sram_state2;

    int tests = 0;
    int fails = 0;

    sram_param_wrapper dut (
        .clk(clk), .n_rst(n_rst), .address(address),
        .read_enable(read_enable), .write_enable(write_enable),
        .write_data(write_data), .byte_en(byte_en),
        .read_data(read_data), .sram_state(sram_state)
    );

    sram_param_wrapper #(.DEPTH(1000)) dut2 (
        .clk(clk), .n_rst(n_rst), .address(address),
        .read_enable(read_enable), .write_enable(write_enable),
        .write_data(write_data), .byte_en(byte_en),
        .read_data(read_data2), .sram_state(sram_state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        logic [1:0]  exp_state;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [1:0] s, input logic [31:0] rd);
        vec_t v;
        v.ren = r; v.wen = w; v.addr = a; v.wdata = d; v.ben = b;
        v.exp_state = s; v.exp_rdata = rd;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic w, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        read_enable = r; write_enable = w; address = a; write_data = d; byte_en = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        add(0, 1, a, d, b, 1, BAD); add(0, 1, a, d, b, 1, BAD);
        add(0, 1, a, d, b, 1, BAD); add(0, 1, a, d, b, 2, BAD);
    endtask

    task automatic add_read(input logic [9:0] a, input logic [31:0] rd);
        add(1, 0, a, 0, 0, 1, BAD); add(1, 0, a, 0, 0, 1, BAD);
        add(1, 0, a, 0, 0, 1, BAD); add(1, 0, a, 0, 0, 2, rd);
    endtask

    task automatic add_idle();
        add(0, 0, 0, 0, 0, 0, BAD);
    endtask

    initial begin
        n_rst = 1'b0; address = '0; read_enable = 0; write_enable = 0;
        write_data = '0; byte_en = '0;

        // Preload known contents at 0x006 and 0x010
        add_write(10'h006, 32'h66666666, 4'hF); add_idle();
        add_write(10'h010, 32'h01010101, 4'hF); add_idle();
        // Full write then read back
        add_write(10'h005, 32'hDEADBEEF, 4'hF);
        add_read (10'h005, 32'hDEADBEEF);
        // Partial byte write merges with existing word
        add_write(10'h005, 32'h11223344, 4'b0101);
        add_read (10'h005, 32'hDE22BE44);
        add_idle();
        // Address change in the 2nd BUSY cycle restarts the read
        add(1, 0, 10'h005, 0, 0, 1, BAD);
        add(1, 0, 10'h005, 0, 0, 1, BAD);
        add(1, 0, 10'h006, 0, 0, 1, BAD);
        add(1, 0, 10'h006, 0, 0, 1, BAD);
        add(1, 0, 10'h006, 0, 0, 1, BAD);
        add(1, 0, 10'h006, 0, 0, 2, 32'h66666666);
        add_idle();
        // Collision: error, no write
        add(1, 1, 10'h010, 32'hCAFEF00D, 4'hF, 3, BAD);
        add(1, 1, 10'h010, 32'hCAFEF00D, 4'hF, 3, BAD);
        add_idle();
        add_read(10'h010, 32'h01010101);
        add_idle();

        #12;
        check("reset_state", {30'd0, sram_state}, 32'd0);
        check("reset_rdata", read_data, BAD);
        @(negedge clk) n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].ben);
            check($sformatf("vec%0d_state", i), {30'd0, sram_state}, {30'd0, vecs[i].exp_state});
            check($sformatf("vec%0d_rdata", i), read_data, vecs[i].exp_rdata);
        end

        // Reset during the 2nd BUSY cycle of a write drops the write
        step(0, 1, 10'h005, 32'h12345678, 4'hF);
        check("rst_wr_busy1", {30'd0, sram_state}, 32'd1);
        step(0, 1, 10'h005, 32'h12345678, 4'hF);
        check("rst_wr_busy2", {30'd0, sram_state}, 32'd1);
        #1 n_rst = 1'b0;
        #1;
        check("rst_mid_state", {30'd0, sram_state}, 32'd0);
        check("rst_mid_rdata", read_data, BAD);
        @(negedge clk);
        read_enable = 0; write_enable = 0;
        @(negedge clk) n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 10'h005, 0, 0);
            check($sformatf("rst_rd%0d_state", k), {30'd0, sram_state}, (k == 3) ? 32'd2 : 32'd1);
            check($sformatf("rst_rd%0d_rdata", k), read_data, (k == 3) ? 32'hDE22BE44 : BAD);
        end
        step(0, 0, 0, 0, 0);
        check("rst_idle", {30'd0, sram_state}, 32'd0);

        // DEPTH=1000 instance: last legal address and first illegal one
        step(1, 0, 10'd1000, 0, 0);
        check("oor_state", {30'd0, sram_state2}, 32'd3);
        check("oor_main_ok", {30'd0, sram_state}, 32'd1);
        step(1, 0, 10'd1000, 0, 0);
        check("oor_hold", {30'd0, sram_state2}, 32'd3);
        step(0, 0, 0, 0, 0);
        check("oor_exit", {30'd0, sram_state2}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 10'd999, 0, 0);
            check($sformatf("d999_%0d_state", k), {30'd0, sram_state2}, (k == 3) ? 32'd2 : 32'd1);
        end
        step(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
